commit_regfile: RTL

//  Architectural register file and register-status (rename) table, directly downstream of the
//  8-entry reorder buffer. Retires in-order commits from the ROB head into the register file.

---
 rtl/commit_regfile.sv | 113 +++++++++++
 1 files changed

// File: rtl/commit_regfile.sv
// Architectural register file plus register-status (rename) table fed by the ROB head.
// Optional macro COMMIT_BYPASS_EN forwards the in-flight commit result to same-cycle lookups.
module commit_regfile #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int TAGW = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     commit_valid,
    input  logic [$clog2(NREG)-1:0]  commit_idx,
    input  logic [XLEN-1:0]          commit_data,
    input  logic [TAGW-1:0]          commit_tag,
    input  logic                     issue_valid,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    input  logic [TAGW-1:0]          issue_tag,
    input  logic                     flush,
    input  logic [$clog2(NREG)-1:0]  rs1,
    input  logic [$clog2(NREG)-1:0]  rs2,
    output logic [XLEN-1:0]          rs1_value,
    output logic                     rs1_busy,
    output logic [TAGW-1:0]          rs1_tag,
    output logic [XLEN-1:0]          rs2_value,
    output logic                     rs2_busy,
    output logic [TAGW-1:0]          rs2_tag,
    output logic                     commit_ack,
    output logic [31:0]              retire_count
);

    localparam int IW = $clog2(NREG);

    logic [XLEN-1:0] regfile [NREG];
    logic [TAGW-1:0] tag_q   [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [TAGW-1:0] tag_d   [NREG];

    // Per-register status update. Rule order gives the priorities:
    // commit clears a matching tag, a later issue overrides it, flush overrides everything.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            tag_d[i] = tag_q[i];
            if (commit_valid && commit_idx == IW'(i) && tag_q[i] == commit_tag)
                busy_d[i] = 1'b0;
            if (issue_valid && issue_rd == IW'(i) && i != 0) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = issue_tag;
            end
        end
        if (flush)
            busy_d = '0;
    end

    // NOTE: the register array is cleared in reset because software may read any
    // register before writing it; this costs a reset mux per bit but is required here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regfile[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q       <= '0;
            commit_ack   <= 1'b0;
            retire_count <= '0;
        end else begin
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            commit_ack <= commit_valid;
            if (commit_valid)
                retire_count <= retire_count + 32'd1;
            if (commit_valid && commit_idx != '0)
                regfile[commit_idx] <= commit_data;
        end
    end

    logic [IW-1:0]   rs_idx  [2];
    logic [XLEN-1:0] rd_val  [2];
    logic            rd_busy [2];
    logic [TAGW-1:0] rd_tag  [2];

    assign rs_idx[0] = rs1;
    assign rs_idx[1] = rs2;

    // Zero-latency lookups; r0 and the reset state read as all zeros.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p]  = '0;
            rd_busy[p] = 1'b0;
            rd_tag[p]  = '0;
            if (rst_n && rs_idx[p] != '0) begin
                rd_val[p]  = regfile[rs_idx[p]];
                rd_busy[p] = busy_q[rs_idx[p]];
                rd_tag[p]  = tag_q[rs_idx[p]];
`ifdef COMMIT_BYPASS_EN
                if (commit_valid && commit_idx == rs_idx[p]) begin
                    rd_val[p] = commit_data;
                    if (tag_q[rs_idx[p]] == commit_tag)
                        rd_busy[p] = 1'b0;
                end
`endif
            end
        end
    end

    assign rs1_value = rd_val[0];
    assign rs1_busy  = rd_busy[0];
    assign rs1_tag   = rd_tag[0];
    assign rs2_value = rd_val[1];
    assign rs2_busy  = rd_busy[1];
    assign rs2_tag   = rd_tag[1];

endmodule
